// File: rtl/dclk_rx_fifo.sv
// Serial frame receiver on wclk feeding a gray-pointer asynchronous FIFO read on rclk.
// Frames are a start beat followed by ITEM_W/LANES data beats, least significant beat first.
module dclk_rx_fifo #(
  parameter int unsigned ITEM_W      = 16,
  parameter int unsigned LANES       = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     rclk,
  input  logic                     wclk,
  input  logic                     reset,
  input  logic [LANES-1:0]         serial_in,
  output logic                     channel_busy,
  output logic                     valid,
  input  logic                     item_read,
  output logic [ITEM_W-1:0]        parallel_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned BEATS = ITEM_W / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  typedef enum logic [1:0] {IDLE, RECV, DROP} wstate_t;

  logic [ITEM_W-1:0] mem [DEPTH];

  // ---------------- wclk domain ----------------
  logic [SYNC_STAGES-1:0]         wrst_sync;
  logic                           wrst;
  logic [SYNC_STAGES-1:0][PW-1:0] rq_w;
  logic [PW-1:0]                  rq_bin_c;
  logic [PW-1:0]                  wptr_bin;
  logic [PW-1:0]                  wptr_gray;
  logic                           wfull_c;
  wstate_t                        state;
  logic [CW-1:0]                  cnt;
  logic                           last_beat_c;
  logic [ITEM_W-1:0]              item_c;
  logic                           ovf_w;

  // rclk-sampled reset carried into wclk; held SYNC_STAGES edges past its fall
  always_ff @(posedge wclk) wrst_sync <= {wrst_sync[SYNC_STAGES-2:0], reset};
  assign wrst = wrst_sync[SYNC_STAGES-1];

  always_ff @(posedge wclk) begin
    if (wrst) rq_w <= '0;
    else      rq_w <= {rq_w[SYNC_STAGES-2:0], rptr_gray};
  end

  assign rq_bin_c     = gray2bin(rq_w[SYNC_STAGES-1]);
  assign wfull_c      = (PW'(wptr_bin - rq_bin_c) == PW'(DEPTH));
  assign last_beat_c  = (cnt == CW'(BEATS - 1));
  assign channel_busy = (state != IDLE) | wfull_c | wrst;

  // Incoming beats enter at the top; after BEATS shifts beat 0 sits in the low bits.
  if (BEATS > 1) begin : g_shift
    logic [ITEM_W-LANES-1:0] shreg;
    always_ff @(posedge wclk) begin
      if (wrst)               shreg <= '0;
      else if (state == RECV) shreg <= item_c[ITEM_W-1:LANES];
    end
    assign item_c = {serial_in, shreg};
  end else begin : g_single
    assign item_c = serial_in;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      cnt       <= '0;
      wptr_bin  <= '0;
      wptr_gray <= '0;
      ovf_w     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (serial_in[0]) begin
            if (wfull_c) begin
              state <= DROP;
              ovf_w <= 1'b1;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (last_beat_c) begin
            state     <= IDLE;
            cnt       <= '0;
            wptr_bin  <= wptr_bin + PW'(1);
            wptr_gray <= bin2gray(wptr_bin + PW'(1));
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DROP: begin
          if (last_beat_c) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst && state == RECV && last_beat_c) mem[wptr_bin[AW-1:0]] <= item_c;
  end

  // ---------------- rclk domain ----------------
  logic [SYNC_STAGES-1:0][PW-1:0] wq_r;
  logic [SYNC_STAGES-1:0]         ovf_r;
  logic [PW-1:0]                  wq_bin_c;
  logic [PW-1:0]                  rptr_bin;
  logic [PW-1:0]                  rptr_gray;
  logic [PW-1:0]                  rptr_n_c;
  logic                           valid_n_c;

  assign wq_bin_c  = gray2bin(wq_r[SYNC_STAGES-1]);
  assign rptr_n_c  = rptr_bin + PW'(valid & item_read);
  assign valid_n_c = (wq_bin_c != rptr_n_c);

  // Show-ahead outputs are registered from the post-pop read pointer.
  always_ff @(posedge rclk) begin
    if (reset) begin
      wq_r         <= '0;
      ovf_r        <= '0;
      rptr_bin     <= '0;
      rptr_gray    <= '0;
      valid        <= 1'b0;
      level        <= '0;
      parallel_out <= '0;
      overflow     <= 1'b0;
    end else begin
      wq_r         <= {wq_r[SYNC_STAGES-2:0], wptr_gray};
      ovf_r        <= {ovf_r[SYNC_STAGES-2:0], ovf_w};
      rptr_bin     <= rptr_n_c;
      rptr_gray    <= bin2gray(rptr_n_c);
      valid        <= valid_n_c;
      level        <= wq_bin_c - rptr_n_c;
      parallel_out <= valid_n_c ? mem[rptr_n_c[AW-1:0]] : '0;
      overflow     <= overflow | ovf_r[SYNC_STAGES-1];
    end
  end

endmodule

// File: tb/tb_dclk_rx_fifo.sv
// Scoreboard bench for dclk_rx_fifo: queue reference model, random frames and reads,
// directed reset, overflow and 4-lane checks.
`timescale 1ns/1ps
module tb_dclk_rx_fifo;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic          rclk = 1'b0;
  logic          wclk = 1'b0;
  logic          reset = 1'b1;
  int            rhalf = 5;
  int            whalf = 5;

  logic          serial1 = 1'b0;
  logic          busy1;
  logic          valid;
  logic          item_read;
  logic [W-1:0]  parallel_out;
  logic [2:0]    level;
  logic          overflow;

  logic [3:0]    serial4 = 4'h0;
  logic          q_busy;
  logic          q_valid;
  logic          q_item_read = 1'b0;
  logic [W-1:0]  q_out;
  logic [2:0]    q_level;
  logic          q_ovf;

  int            total = 0;
  int            bad = 0;
  int            rd_mode = 0;
  logic [W-1:0]  exp_q[$];

  dclk_rx_fifo #(.ITEM_W(W), .LANES(1), .DEPTH(D), .SYNC_STAGES(S)) u_dut (
    .rclk(rclk), .wclk(wclk), .reset(reset), .serial_in(serial1),
    .channel_busy(busy1), .valid(valid), .item_read(item_read),
    .parallel_out(parallel_out), .level(level), .overflow(overflow));

  dclk_rx_fifo #(.ITEM_W(W), .LANES(4), .DEPTH(D), .SYNC_STAGES(S)) u_quad (
    .rclk(rclk), .wclk(wclk), .reset(reset), .serial_in(serial4),
    .channel_busy(q_busy), .valid(q_valid), .item_read(q_item_read),
    .parallel_out(q_out), .level(q_level), .overflow(q_ovf));

  always begin #(rhalf); rclk = ~rclk; end
  initial begin #2; forever begin #(whalf); wclk = ~wclk; end end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop request driver: 0 never, 1 random, 2 always.
  initial begin
    item_read = 1'b0;
    forever begin
      @(posedge rclk); #1;
      case (rd_mode)
        0:       item_read = 1'b0;
        1:       item_read = 1'($urandom_range(0, 1));
        default: item_read = 1'b1;
      endcase
    end
  end

  // Monitor: every accepted pop must deliver the oldest outstanding frame.
  initial begin
    forever begin
      @(negedge rclk);
      if (!reset) begin
        if (valid && exp_q.size() == 0)
          check("valid_without_item", 32'(valid), 32'd0);
        else if (valid && item_read)
          check("pop_data", 32'(parallel_out), 32'(exp_q.pop_front()));
        if (!valid) check("out_zero_when_empty", 32'(parallel_out), 32'd0);
        check("level_bound", 32'(level <= 3'(D)), 32'd1);
      end
    end
  end

  task automatic send_frame(input logic [W-1:0] item, input bit force_start);
    int guard = 0;
    @(negedge wclk);
    while (busy1 && !force_start) begin
      serial1 = 1'b0;
      guard++;
      if (guard > 3000) begin
        check("send_wait_timeout", 32'(busy1), 32'd0);
        return;
      end
      @(negedge wclk);
    end
    serial1 = 1'b1;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge wclk);
      serial1 = item[k];
    end
  endtask

  task automatic idle_line();
    @(negedge wclk);
    serial1 = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge rclk);
      n++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    reset   = 1'b1;
    serial1 = 1'b0;
    serial4 = 4'h0;
    repeat (10) @(posedge rclk);
    repeat (4) @(posedge wclk);
    @(negedge rclk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out", 32'(parallel_out), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    @(negedge wclk);
    check("rst_busy", 32'(busy1), 32'd1);
    check("rst_q_busy", 32'(q_busy), 32'd1);
    @(posedge rclk); #1;
    reset = 1'b0;
    @(posedge wclk); @(negedge wclk);
    check("busy_held_after_release", 32'(busy1), 32'd1);
    repeat (S) @(posedge wclk);
    @(negedge wclk);
    check("busy_released", 32'(busy1), 32'd0);
  endtask

  initial begin
    logic [W-1:0] item;
    logic [3:0]   qb [4];
    qb = '{4'h3, 4'hC, 4'h5, 4'hA};

    do_reset();

    // Single lane frame 0xA5C3 with latency bound, then one pop.
    item = 16'hA5C3;
    exp_q.push_back(item);
    send_frame(item, 1'b0);
    @(posedge wclk);
    idle_line();
    repeat (S + 1) @(posedge rclk);
    @(negedge rclk);
    check("lat_valid", 32'(valid), 32'd1);
    check("lat_data", 32'(parallel_out), 32'hA5C3);
    check("lat_level", 32'(level), 32'd1);
    rd_mode = 2;
    @(posedge rclk); #2;
    rd_mode = 0;
    repeat (3) @(negedge rclk);
    check("after_pop_valid", 32'(valid), 32'd0);
    check("after_pop_level", 32'(level), 32'd0);

    // Four-lane frame: start beat with don't-care upper lanes, then nibbles 3,C,5,A.
    @(negedge wclk);
    serial4 = {3'($urandom_range(0, 7)), 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      serial4 = qb[k];
    end
    @(negedge wclk);
    serial4 = 4'h0;
    repeat (S + 3) @(posedge rclk);
    @(negedge rclk);
    check("quad_valid", 32'(q_valid), 32'd1);
    check("quad_data", 32'(q_out), 32'hA5C3);
    check("quad_level", 32'(q_level), 32'd1);
    q_item_read = 1'b1;
    @(negedge rclk);
    q_item_read = 1'b0;
    repeat (2) @(negedge rclk);
    check("quad_empty", 32'(q_valid), 32'd0);
    check("quad_out_zero", 32'(q_out), 32'd0);
    check("quad_no_overflow", 32'(q_ovf), 32'd0);

    // Fill to DEPTH, then a forced frame must be dropped and flagged.
    for (int n = 1; n <= int'(D); n++) begin
      item = W'(n);
      exp_q.push_back(item);
      send_frame(item, 1'b0);
    end
    @(posedge wclk);
    idle_line();
    check("full_busy", 32'(busy1), 32'd1);
    repeat (S + 3) @(negedge rclk);
    check("full_level", 32'(level), 32'(D));
    send_frame(16'h0005, 1'b1);
    idle_line();
    repeat (S + 6) @(negedge rclk);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_level", 32'(level), 32'(D));
    check("drop_head", 32'(parallel_out), 32'd1);
    rd_mode = 2;
    drain(200);
    repeat (4) @(negedge rclk);
    rd_mode = 0;
    check("drained_level", 32'(level), 32'd0);
    check("drained_valid", 32'(valid), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame after 7 data beats; the next frame must be intact.
    @(negedge wclk);
    while (busy1) @(negedge wclk);
    serial1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge wclk);
      serial1 = 1'($urandom_range(0, 1));
    end
    do_reset();
    item = 16'h5A3C;
    exp_q.push_back(item);
    send_frame(item, 1'b0);
    idle_line();
    rd_mode = 1;
    drain(500);
    rd_mode = 0;

    // Random back-to-back frames at both clock ratios.
    for (int cfg = 0; cfg < 2; cfg++) begin
      if (cfg == 0) begin rhalf = 15; whalf = 5; end
      else          begin rhalf = 5;  whalf = 15; end
      do_reset();
      rd_mode = 1;
      for (int n = 0; n < 100; n++) begin
        item = W'($urandom);
        exp_q.push_back(item);
        send_frame(item, 1'b0);
      end
      idle_line();
      drain(20000);
      rd_mode = 0;
      repeat (4) @(negedge rclk);
      check("random_no_overflow", 32'(overflow), 32'd0);
      check("random_final_level", 32'(level), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dclk_rx_fifo.md
DCLK_RX_FIFO -- requirements
Module: dclk_rx_fifo

Interface
REQ-001 SHALL have parameter ITEM_W, default 16: received item width in bits (payload plus address).
REQ-002 SHALL have parameter LANES, default 1: number of parallel serial lanes; ITEM_W mod LANES = 0.
REQ-003 SHALL have parameter DEPTH, default 4: item buffer entries; power of 2, at least 2.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: flops per clock-domain-crossing synchroniser, at least 2.
REQ-005 SHALL have port rclk, input, 1: read-side clock.
REQ-006 SHALL have port wclk, input, 1: serial-line (write-side) clock, asynchronous to rclk.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high, sampled on rclk.
REQ-008 SHALL have port serial_in, input, LANES: serial data (wclk domain).
REQ-009 SHALL have port channel_busy, output, 1: wclk domain; sender must not start a frame while it is high.
REQ-010 SHALL have port valid, output, 1: rclk domain; parallel_out holds the oldest buffered item.
REQ-011 SHALL have port item_read, input, 1: rclk domain; pop request.
REQ-012 SHALL have port parallel_out, output, ITEM_W: head item.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1: rclk-domain occupancy.
REQ-014 SHALL have port overflow, output, 1: sticky dropped-frame flag (rclk domain).

Function
REQ-015 Frame SHALL be one start beat followed by BEATS = ITEM_W/LANES data beats, one beat per wclk edge; data beat k carries item bits [k*LANES +: LANES], so bit 0 arrives first.
REQ-016 Start beat SHALL be recognised when the receiver is IDLE and serial_in[0]=1; other lanes are don't-care during the start beat.
REQ-017 Write FSM SHALL have states IDLE, RECV, DROP: IDLE->RECV on start with buffer not full; IDLE->DROP on start with buffer full; RECV or DROP returns to IDLE after the BEATS-th data beat.
REQ-018 A beat counter SHALL count 0..BEATS-1 and clear on every return to IDLE.
REQ-019 On the last RECV beat, the assembled item SHALL be written to the buffer on that same wclk edge.
REQ-020 Back-to-back frames SHALL be accepted: a start beat on the wclk edge after the last data beat is valid.
REQ-021 DROP SHALL consume the frame without writing and SHALL set overflow; overflow reaches the rclk domain via a SYNC_STAGES synchroniser.
REQ-022 channel_busy SHALL equal (state != IDLE) OR write-side full OR wclk-domain reset active.
REQ-023 Buffer SHALL be an asynchronous FIFO with gray-coded (log2(DEPTH)+1)-bit pointers, each crossing through SYNC_STAGES flops; full and empty are conservative, with no false not-full or not-empty.
REQ-024 Read side SHALL be show-ahead: valid = not empty, and parallel_out = head entry, stable while valid and item_read is low.
REQ-025 Pop SHALL occur on an rclk edge with valid AND item_read; item_read while valid is low SHALL be ignored, with no pointer change.
REQ-026 Pop rate SHALL be one item per rclk cycle while not empty.
REQ-027 Latency SHALL be at most SYNC_STAGES+2 rclk edges from the write wclk edge to valid high.
REQ-028 level SHALL be (write pointer synchronised to rclk) - (read pointer), modulo 2^(log2(DEPTH)+1), and SHALL never exceed DEPTH.
REQ-029 A write and a pop in the same period SHALL both take effect; no item is lost or duplicated.
REQ-030 parallel_out SHALL be 0 while valid is low.

Reset
REQ-031 On an rclk edge with reset=1: read pointer=0, valid=0, level=0, overflow=0, parallel_out=0.
REQ-032 reset SHALL be synchronised into wclk through SYNC_STAGES flops, and the wclk-domain reset SHALL stay asserted at least SYNC_STAGES wclk edges after reset falls.
REQ-033 wclk-domain reset SHALL put the FSM in IDLE, clear the counter, shift register and write pointer, and discard any partial frame.
REQ-034 channel_busy SHALL be 1 throughout wclk-domain reset.
REQ-035 After wclk-domain reset releases, channel_busy SHALL be 0 within 1 wclk edge.

Verification
REQ-036 With ITEM_W=16, LANES=1: start beat, then bits of 0xA5C3 LSB-first -> within 4 rclk edges valid=1, parallel_out=0xA5C3, level=1; item_read pulse -> valid=0, level=0.
REQ-037 With ITEM_W=16, LANES=4: start beat, then beats 0x3, 0xC, 0x5, 0xA -> parallel_out=0xA5C3.
REQ-038 DEPTH=4, no reads, 4 frames 0x0001..0x0004 -> level=4, channel_busy=1; 5th frame forced -> overflow=1, level=4; 4 consecutive reads return 1, 2, 3, 4 in order.
REQ-039 Reset mid-frame after 7 data beats -> valid=0, level=0, overflow=0; channel_busy=1 then 0 after release; the next full frame is received intact.
REQ-040 wclk = 3x rclk and wclk = rclk/3, 100 random back-to-back frames with random item_read -> output sequence equals input sequence, no overflow.
